// File: rtl/sram_c.sv
// Buffer C of the NPU datapath: 1024 x 8 single-port synchronous SRAM.
// Shared read/write address, registered write-first read port, async reset on the output only.
module sram_c (
    input  logic       rpll_clk,
    input  logic       rst,
    input  logic       sram_C_we,
    input  logic [9:0] sram_C_addr,
    input  logic [7:0] sram_C_din,
    output logic [7:0] sram_C_dout
);

    localparam int DEPTH = 1024;

    logic [7:0] mem [0:DEPTH-1];
    logic       wr_en;

    assign wr_en = sram_C_we && !rst;

    // The array has no reset so it maps onto a single block RAM; contents survive rst.
    always_ff @(posedge rpll_clk) begin
        if (wr_en) begin
            mem[sram_C_addr] <= sram_C_din;
        end
    end

    always_ff @(posedge rpll_clk or posedge rst) begin
        if (rst) begin
            sram_C_dout <= 8'h00;
        end else if (sram_C_we) begin
            sram_C_dout <= sram_C_din;
        end else begin
            sram_C_dout <= mem[sram_C_addr];
        end
    end

endmodule

// File: tb/tb_sram_c.sv
// Self-checking bench for sram_c: stimulus pushes expected read data into a queue,
// a monitor pops and compares one cycle later; reference is a plain byte array.
`timescale 1ns/10ps
module tb_sram_c;

    logic       rpll_clk;
    logic       rst;
    logic       sram_C_we;
    logic [9:0] sram_C_addr;
    logic [7:0] sram_C_din;
    logic [7:0] sram_C_dout;

    sram_c dut (
        .rpll_clk    (rpll_clk),
        .rst         (rst),
        .sram_C_we   (sram_C_we),
        .sram_C_addr (sram_C_addr),
        .sram_C_din  (sram_C_din),
        .sram_C_dout (sram_C_dout)
    );

    initial rpll_clk = 1'b0;
    always #10.58 rpll_clk = ~rpll_clk;

    typedef struct {
        int         edge_n;
        logic [7:0] exp;
        string      nm;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] ref_mem [0:1023];
    bit         ref_ok  [0:1023];
    int         cyc     = 0;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: after each rising edge, compare every expectation tagged for that edge.
    initial begin
        forever begin
            @(posedge rpll_clk);
            #1;
            cyc++;
            while (sb.size() > 0 && sb[0].edge_n <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                if (e.edge_n < cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s: stale expectation for edge %0d at edge %0d", e.nm, e.edge_n, cyc);
                end else begin
                    check(e.nm, sram_C_dout, e.exp);
                end
            end
        end
    end

    // One cycle of stimulus applied at the falling edge; the model decides what the
    // output must be after the next rising edge.
    task automatic op(input bit r, input bit we, input logic [9:0] a,
                      input logic [7:0] d, input string nm);
        exp_t e;
        @(negedge rpll_clk);
        rst         = r;
        sram_C_we   = we;
        sram_C_addr = a;
        sram_C_din  = d;
        e.edge_n = cyc + 1;
        e.nm     = nm;
        if (r) begin
            e.exp = 8'h00;
            sb.push_back(e);
        end else if (we) begin
            ref_mem[a] = d;
            ref_ok[a]  = 1'b1;
            e.exp = d;
            sb.push_back(e);
        end else if (ref_ok[a]) begin
            e.exp = ref_mem[a];
            sb.push_back(e);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_ok[i] = 1'b0;
        rst         = 1'b1;
        sram_C_we   = 1'b0;
        sram_C_addr = '0;
        sram_C_din  = '0;
        #5;
        check("reset_state", sram_C_dout, 8'h00);
        op(1, 0, 10'd0, 8'h00, "reset_hold");
        op(1, 0, 10'd0, 8'h00, "reset_hold");

        // Basic write/read.
        op(0, 1, 10'd0, 8'hCC, "wr0_first");
        op(0, 0, 10'd0, 8'h00, "rd0");

        // Write-first: location 10 holds a different value beforehand.
        op(0, 1, 10'd10, 8'h33, "wr10_pre");
        op(0, 0, 10'd0,  8'h00, "rd0_again");
        op(0, 1, 10'd10, 8'h5A, "write_first");
        op(0, 0, 10'd10, 8'h00, "rd10_after");

        // Boundaries, no aliasing between 0 and 1023.
        op(0, 1, 10'd0,    8'h01, "wr_lo");
        op(0, 1, 10'd1023, 8'hFE, "wr_hi");
        op(0, 0, 10'd0,    8'h00, "rd_lo");
        op(0, 0, 10'd1023, 8'h00, "rd_hi");
        op(0, 0, 10'd512,  8'h00, "rd_unwritten");

        // Async reset and writes blocked while rst is high.
        op(0, 1, 10'd5, 8'h11, "wr5_known");
        @(negedge rpll_clk);
        #3;
        sram_C_we   = $urandom_range(0, 1);
        sram_C_addr = 10'($urandom_range(0, 1023));
        sram_C_din  = 8'($urandom);
        rst         = 1'b1;
        #1;
        check("rst_async_dout", sram_C_dout, 8'h00);
        op(1, 1, 10'd5, 8'h77, "rst_blocks_wr");
        op(1, 1, 10'd5, 8'h77, "rst_blocks_wr");
        op(0, 0, 10'd5, 8'h00, "rd5_after_rst");
        op(0, 0, 10'd0, 8'h00, "rd_lo_after_rst");

        // Retention across a reset pulse.
        op(0, 1, 10'd512, 8'h3C, "wr512");
        op(0, 0, 10'd1,   8'h00, "rd1_unwritten");
        @(negedge rpll_clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_pulse_dout", sram_C_dout, 8'h00);
        op(0, 0, 10'd512, 8'h00, "retain512");

        // Sweep: write every location, then read all back-to-back.
        for (int i = 0; i < 1024; i++)
            op(0, 1, 10'(i), 8'(i) ^ 8'hA5, "sweep_wr");
        for (int i = 0; i < 1024; i++)
            op(0, 0, 10'(i), 8'h00, "sweep_rd");

        // Random mix of reads and writes (every location is now known).
        for (int i = 0; i < 400; i++)
            op(0, ($urandom_range(0, 2) == 0), 10'($urandom_range(0, 1023)),
               8'($urandom), "random");
        for (int i = 0; i < 40; i++)
            op(0, 0, 10'($urandom_range(0, 1023)), 8'h00, "random_rd");

        @(negedge rpll_clk);
        sram_C_we = 1'b0;
        repeat (3) @(negedge rpll_clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
